// File: rtl/sample_pkg.sv
// sample_pkg: shared constants, state encoding and the pending-set priority
// encoder for the sample capture path.
//   NUM_CH    - number of logic channels
//   GROUP_LEN - samples per channel per emitted word
//   state_e   - capture FSM states
//   lowest_set() - index of the lowest set bit (0 when none set)
package sample_pkg;

    localparam int unsigned NUM_CH    = 16;
    localparam int unsigned GROUP_LEN = 16;
    localparam int unsigned CH_W      = $clog2(NUM_CH);
    localparam int unsigned IDX_W     = $clog2(GROUP_LEN);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVERRUN
    } state_e;

    function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
        logic [CH_W-1:0] idx;
        idx = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (v[i-1]) idx = CH_W'(i - 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/channel_transposer.sv
// channel_transposer: per-channel shift bank that collects GROUP_LEN samples
// of every channel into one word each, plus a hold bank that keeps the last
// completed group while it is being emitted.
//   clk, rst_n  - capture clock, async active-low reset
//   strobe_i    - write sample_i into bit idx_i of every shift word
//   idx_i       - sample index within the group (bit 0 = earliest)
//   transfer_i  - copy the completing group into the hold bank
//   sample_i    - current channel inputs
//   rd_ch_i     - channel whose held word is read
//   rd_word_o   - held word of rd_ch_i
module channel_transposer
    import sample_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 strobe_i,
    input  logic [IDX_W-1:0]     idx_i,
    input  logic                 transfer_i,
    input  logic [NUM_CH-1:0]    sample_i,
    input  logic [CH_W-1:0]      rd_ch_i,
    output logic [GROUP_LEN-1:0] rd_word_o
);

    logic [GROUP_LEN-1:0] shift_q [NUM_CH];
    logic [GROUP_LEN-1:0] hold_q  [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shift_q[i] <= '0;
                hold_q[i]  <= '0;
            end
        end else begin
            if (strobe_i) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    shift_q[i][idx_i] <= sample_i[i];
                end
            end
            // Transfer coincides with the last strobe of the group, so the
            // top bit comes straight from the inputs.
            if (transfer_i) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    hold_q[i] <= {sample_i[i], shift_q[i][GROUP_LEN-2:0]};
                end
            end
        end
    end

    // Bypass on the transfer cycle lets the first word of a group be
    // registered on the same edge that fills the hold bank.
    always_comb begin
        if (transfer_i) begin
            rd_word_o = {sample_i[rd_ch_i], shift_q[rd_ch_i][GROUP_LEN-2:0]};
        end else begin
            rd_word_o = hold_q[rd_ch_i];
        end
    end

endmodule

// File: rtl/sample_packer.sv
// sample_packer: capture-side FIFO writer. Samples sample_in every divider+1
// clocks, transposes each group of 16 samples into one word per channel and
// writes the enabled channels' words, lowest channel first, to the FIFO.
//   clk, rst_n        - capture clock, async active-low reset
//   enable            - run request (level)
//   divider           - strobe period minus one, latched at start
//   channel_mask      - emitted channels, latched at start
//   sample_in         - synchronized channel inputs
//   fifo_full         - FIFO write-side full flag
//   sample_data       - FIFO din
//   sample_data_avail - FIFO wr_en
//   capturing         - high while running
//   overrun           - sticky overflow flag, cleared on next start
module sample_packer
    import sample_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DIV_W-1:0]  divider,
    input  logic [NUM_CH-1:0] channel_mask,
    input  logic [NUM_CH-1:0] sample_in,
    input  logic              fifo_full,
    output logic [15:0]       sample_data,
    output logic              sample_data_avail,
    output logic              capturing,
    output logic              overrun
);

    state_e               state_q;
    logic [DIV_W-1:0]     div_q;
    logic [DIV_W-1:0]     cnt_q;
    logic [NUM_CH-1:0]    mask_q;
    logic [IDX_W-1:0]     scount_q;
    logic [NUM_CH-1:0]    pending_q, pending_d;
    logic [15:0]          data_q;
    logic                 due_q, due_d;
    logic                 capturing_q;
    logic                 overrun_q;

    logic                 overflow;
    logic                 strobe;
    logic                 transfer;
    logic [NUM_CH-1:0]    emit_src;
    logic [CH_W-1:0]      emit_ch;
    logic [GROUP_LEN-1:0] rd_word;

    // A registered word is only released when the FIFO has room in that
    // same cycle; a full FIFO at that point is the overflow condition.
    assign overflow = due_q & fifo_full;

    always_comb begin
        strobe    = (state_q == RUN) && enable && !overflow && (cnt_q == '0);
        transfer  = strobe && (scount_q == IDX_W'(GROUP_LEN - 1));
        // On a transfer the fresh mask becomes the pending set immediately.
        emit_src  = transfer ? mask_q : pending_q;
        emit_ch   = lowest_set(emit_src);
        pending_d = emit_src & ~(NUM_CH'(1) << emit_ch);
        due_d     = |emit_src;
    end

    channel_transposer u_transposer (
        .clk        (clk),
        .rst_n      (rst_n),
        .strobe_i   (strobe),
        .idx_i      (scount_q),
        .transfer_i (transfer),
        .sample_i   (sample_in),
        .rd_ch_i    (emit_ch),
        .rd_word_o  (rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            scount_q    <= '0;
            pending_q   <= '0;
            data_q      <= '0;
            due_q       <= 1'b0;
            capturing_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    due_q <= 1'b0;
                    if (enable) begin
                        state_q     <= RUN;
                        div_q       <= divider;
                        mask_q      <= channel_mask;
                        cnt_q       <= '0;
                        scount_q    <= '0;
                        pending_q   <= '0;
                        overrun_q   <= 1'b0;
                        capturing_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_q     <= IDLE;
                        capturing_q <= 1'b0;
                        due_q       <= 1'b0;
                        pending_q   <= '0;
                    end else if (overflow) begin
                        state_q     <= OVERRUN;
                        overrun_q   <= 1'b1;
                        capturing_q <= 1'b0;
                        due_q       <= 1'b0;
                        pending_q   <= '0;
                    end else begin
                        cnt_q     <= strobe ? div_q : cnt_q - DIV_W'(1);
                        if (strobe) scount_q <= scount_q + IDX_W'(1);
                        pending_q <= pending_d;
                        due_q     <= due_d;
                        if (due_d) data_q <= rd_word;
                    end
                end
                OVERRUN: begin
                    if (!enable) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sample_data       = data_q;
    assign sample_data_avail = due_q & ~fifo_full;
    assign capturing         = capturing_q;
    assign overrun           = overrun_q;

endmodule

// File: tb/tb_sample_packer.sv
module tb_sample_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  divider = '0;
    logic [15:0] channel_mask = '0;
    logic [15:0] sample_in = '0;
    logic        fifo_full = 1'b0;
    logic [15:0] sample_data;
    logic        sample_data_avail;
    logic        capturing;
    logic        overrun;

    sample_packer #(.DIV_W(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .divider           (divider),
        .channel_mask      (channel_mask),
        .sample_in         (sample_in),
        .fifo_full         (fifo_full),
        .sample_data       (sample_data),
        .sample_data_avail (sample_data_avail),
        .capturing         (capturing),
        .overrun           (overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: 0 = idle, 1 = running, 2 = overflowed.
    int          mst = 0;
    bit          m_ovr = 1'b0;
    int          m_d = 0;
    logic [15:0] m_mask = '0;
    int          rc = 0;          // run cycle number, 1 = first run cycle
    logic [15:0] m_samp [16];
    int          m_n = 0;
    logic [15:0] q_word [$];
    int          q_due  [$];
    int          gc = 0;          // global cycle counter
    logic [15:0] wlog   [$];      // every word the DUT writes

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, gc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic        due;
        logic        ea;
        logic [15:0] w;
        int          k;
        gc++;
        if (!rst_n) begin
            mst = 0; m_ovr = 1'b0; m_n = 0; rc = 0;
            q_word.delete(); q_due.delete();
            chk("rst_avail", sample_data_avail, 0);
            chk("rst_capturing", capturing, 0);
            chk("rst_overrun", overrun, 0);
            chk("rst_data", sample_data, 0);
        end else begin
            due = (mst == 1) && (q_due.size() > 0) && (q_due[0] == gc);
            ea  = due && !fifo_full;
            chk("avail", sample_data_avail, ea);
            if (ea) chk("data", sample_data, q_word[0]);
            chk("capturing", capturing, (mst == 1));
            chk("overrun", overrun, m_ovr);
            if (sample_data_avail) wlog.push_back(sample_data);

            case (mst)
                0: if (enable) begin
                    mst = 1; m_d = int'(divider); m_mask = channel_mask;
                    m_ovr = 1'b0; rc = 1; m_n = 0;
                    q_word.delete(); q_due.delete();
                end
                1: if (!enable) begin
                    mst = 0; q_word.delete(); q_due.delete();
                end else if (due && fifo_full) begin
                    mst = 2; m_ovr = 1'b1; q_word.delete(); q_due.delete();
                end else begin
                    if (due) begin
                        void'(q_word.pop_front());
                        void'(q_due.pop_front());
                    end
                    if (((rc - 1) % (m_d + 1)) == 0) begin
                        m_samp[m_n] = sample_in;
                        m_n++;
                        if (m_n == 16) begin
                            k = 1;
                            for (int ch = 0; ch < 16; ch++) begin
                                if (m_mask[ch]) begin
                                    for (int s = 0; s < 16; s++) w[s] = m_samp[s][ch];
                                    q_word.push_back(w);
                                    q_due.push_back(gc + k);
                                    k++;
                                end
                            end
                            m_n = 0;
                        end
                    end
                    rc++;
                end
                default: if (!enable) mst = 0;
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns in run cycle 1 (the edge that samples enable is edge 0).
    task automatic start(input int d, input logic [15:0] m);
        divider = 8'(d);
        channel_mask = m;
        enable = 1'b1;
        step(1);
        divider = 8'($urandom);
        channel_mask = 16'($urandom);
    endtask

    task automatic stop();
        enable = 1'b0;
        fifo_full = 1'b0;
        step(2);
    endtask

    task automatic wait_writes(input int n, input int budget);
        int c;
        c = 0;
        while (wlog.size() < n && c < budget) begin
            sample_in = 16'($urandom);
            step(1);
            c++;
        end
        chk("wait_writes", wlog.size(), n);
    endtask

    initial begin
        int base;
        step(3);
        chk("reset_avail", sample_data_avail, 0);
        chk("reset_capturing", capturing, 0);
        rst_n = 1'b1;
        step(2);

        // Counting pattern, all channels, full rate.
        wlog.delete();
        start(0, 16'hFFFF);
        for (int s = 0; s < 16; s++) begin
            sample_in = 16'(s);
            step(1);
        end
        sample_in = '0;
        step(16);
        chk("t1_count", wlog.size(), 16);
        chk("t1_ch0", wlog[0], 16'hAAAA);
        chk("t1_ch1", wlog[1], 16'hCCCC);
        chk("t1_ch2", wlog[2], 16'hF0F0);
        chk("t1_ch3", wlog[3], 16'hFF00);
        chk("t1_ch4", wlog[4], 16'h0000);
        chk("t1_ch15", wlog[15], 16'h0000);
        stop();

        // Divider 3, three channels, constant input.
        wlog.delete();
        start(3, 16'h8005);
        sample_in = 16'h8001;
        step(136);
        chk("t2_count", wlog.size(), 6);
        chk("t2_w0", wlog[0], 16'hFFFF);
        chk("t2_w1", wlog[1], 16'h0000);
        chk("t2_w2", wlog[2], 16'hFFFF);
        chk("t2_w3", wlog[3], 16'hFFFF);
        chk("t2_w4", wlog[4], 16'h0000);
        chk("t2_w5", wlog[5], 16'hFFFF);
        stop();

        // Empty mask: capture runs, nothing written.
        wlog.delete();
        start(0, 16'h0000);
        for (int i = 0; i < 70; i++) begin
            sample_in = 16'($urandom);
            step(1);
        end
        chk("t3_count", wlog.size(), 0);
        chk("t3_capturing", capturing, 1);
        stop();

        // FIFO full when the second word is due.
        wlog.delete();
        start(0, 16'hFFFF);
        wait_writes(1, 40);
        fifo_full = 1'b1;
        step(1);
        fifo_full = 1'b0;
        chk("t4_capturing", capturing, 0);
        chk("t4_overrun", overrun, 1);
        step(3);
        chk("t4_count", wlog.size(), 1);
        stop();
        chk("t4_overrun_idle", overrun, 1);
        start(0, 16'hFFFF);
        chk("t4_overrun_cleared", overrun, 0);
        chk("t4_restart_capturing", capturing, 1);
        stop();

        // Abort a partial group, restart: only new samples appear.
        start(0, 16'hFFFF);
        sample_in = 16'hFFFF;
        step(9);
        stop();
        wlog.delete();
        start(0, 16'hFFFF);
        sample_in = 16'h0001;
        step(1);
        sample_in = 16'h0000;
        step(31);
        chk("t5_count", wlog.size(), 16);
        chk("t5_ch0", wlog[0], 16'h0001);
        chk("t5_ch1", wlog[1], 16'h0000);
        chk("t5_ch15", wlog[15], 16'h0000);
        stop();

        // Asynchronous reset during emission.
        wlog.delete();
        start(0, 16'hFFFF);
        wait_writes(4, 40);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("t6_avail", sample_data_avail, 0);
        chk("t6_capturing", capturing, 0);
        step(2);
        rst_n = 1'b1;
        base = wlog.size();
        step(40);
        chk("t6_no_writes", wlog.size(), base);

        // Randomized runs with random full flags and enable drops.
        for (int r = 0; r < 6; r++) begin
            start(int'($urandom_range(0, 3)), 16'($urandom));
            for (int i = 0; i < 300 + int'($urandom_range(0, 200)); i++) begin
                sample_in    = 16'($urandom);
                fifo_full    = ($urandom_range(0, 63) == 0);
                divider      = 8'($urandom_range(0, 3));
                channel_mask = 16'($urandom);
                enable       = ($urandom_range(0, 199) != 0);
                step(1);
            end
            stop();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sample_packer.md
# sample_packer

Capture-side writer for the sample FIFO: samples the 16 synchronized logic inputs at a programmable rate, transposes each enabled channel's 16 consecutive samples into one 16-bit word, and writes those words into the sample FIFO (`sample_data` / `sample_data_avail`) in the `fastclk` domain. It is the producer for the FIFO whose read side streams to the host. Word order per 16-sample group is ascending channel index over the enabled channels. FIFO overflow is detected and latched.

## Interface
- `DIV_W`, 8: width of the sample-rate divider.
- `clk` in 1: capture clock (`fastclk`).
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: capture run request; level-sensitive.
- `divider` in DIV_W: sample strobe every `divider+1` clocks; latched at start.
- `channel_mask` in 16: bit i set means channel i is emitted; latched at start.
- `sample_in` in 16: channel inputs, already synchronized to `clk`.
- `fifo_full` in 1: FIFO full flag, write side.
- `sample_data` out 16: word to FIFO `din`.
- `sample_data_avail` out 1: FIFO `wr_en`; one word per high cycle.
- `capturing` out 1: high in RUN.
- `overrun` out 1: sticky overflow flag.

## Operation
- States: IDLE, RUN, OVERRUN. Reset puts the block in IDLE. Outputs at reset: all 0. Shift bank, hold bank, counters are 0.
- IDLE → RUN on a clock with `enable`=1. On that edge:
  - latch `divider` and `channel_mask`;
  - clear `overrun`, the divider counter, and the sample count.
- RUN strobe rule: a sample strobe occurs on every cycle where the divider counter is 0. On a strobe, the counter reloads to the latched divider. Otherwise it decrements.
- On a strobe, for every channel i, shift `sample_in[i]` into shift word i at bit position `sample_count`. Bit 0 holds the earliest sample. Then `sample_count` increments mod 16.
- On the strobe with `sample_count`=15:
  - copy all 16 completed shift words into the hold bank;
  - load the pending-channel set with the latched mask.
- Emission: while the pending set is non-empty, emit one word per clock. Each word is the hold-bank word of the lowest pending channel; that channel is then cleared from the pending set.
- Emission of a group is always finished before the next group is transferred. With divider=0 and all 16 channels enabled, this is exactly 16 words in 16 clocks.
- Mask 0: capture runs and no words are ever emitted.
- RUN → IDLE when `enable`=0:
  - the partial group and any undrained pending words are discarded;
  - `sample_data_avail` is 0 from the next cycle.
- RUN → OVERRUN when a word is due on a cycle with `fifo_full`=1. On that cycle:
  - the word is not written (`sample_data_avail`=0);
  - `overrun` is set to 1;
  - strobing and emission stop.
- OVERRUN → IDLE when `enable`=0. `overrun` stays set until the next IDLE → RUN transition.
- Mid-operation `rst_n` low: immediate return to the reset state, with outputs 0 asynchronously.

## Timing
- Let the `enable`-sampled edge be edge 0. First RUN cycle is cycle 1: `capturing`=1, and the first strobe occurs in cycle 1.
- Strobes fall on cycles 1 + k·(D+1), where D is the latched divider.
- The 16th strobe of a group is on cycle t. The first word of that group appears (registered `sample_data`/`sample_data_avail`) in cycle t+1; the n-th enabled word appears in cycle t+n.
- `fifo_full` is sampled in the same cycle the write would assert. No write is ever issued while `fifo_full`=1.
- `capturing` drops in the cycle after `enable` is sampled low, or in the cycle after the overrun is detected.

## Structure
- Shared package `sample_pkg`: `NUM_CH`=16, `GROUP_LEN`=16, state encodings IDLE/RUN/OVERRUN.
- Sub-module `channel_transposer`: 16×16 shift bank plus hold bank. Inputs: strobe, sample index, transfer pulse. Output: the hold-bank word for a channel index.
- The top holds the FSM, the divider counter, and the priority encoder over the pending set.

## Test plan
- Divider 0, mask 0xFFFF, `sample_in` = count 0,1,2…15 on the strobes → 16 consecutive writes starting at t+1. Channel 0 word = 0xAAAA, channel 1 = 0xCCCC, channel 3 = 0xFF00, channel 4..15 = 0x0000.
- Divider 3, mask 0x8005, `sample_in` constant 0x8001 → strobes every 4 clocks. Per group, exactly 3 writes in the order ch0=0xFFFF, ch2=0x0000, ch15=0xFFFF.
- Mask 0x0000, 64 strobes → zero writes, `capturing`=1 throughout.
- `fifo_full` high when the 2nd word of a group is due → 1 write only, `overrun`=1, `capturing`=0 next cycle. Deassert then reassert `enable` → `overrun` is 0 in the first new RUN cycle.
- `enable` low after 9 strobes, restart with divider 0 → first group holds only new samples, and bit 0 is the first new strobe.
- `rst_n` pulse during emission → `sample_data_avail`=0 immediately, IDLE, no further writes.
